// File: rtl/iir_pkg.sv
// Shared IIR definitions: default widths, load length, coefficient word
// type and loader state encoding, used by the loader, filter and bench.
package iir_pkg;

    localparam int NB_DEF  = 12;
    localparam int ORD_DEF = 2;
    localparam int NC_DEF  = 2 * ORD_DEF + 1;

    typedef logic [NB_DEF:0] coeff_t;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        DRAIN    = 2'd1,
        WAIT_GAP = 2'd2,
        COMMIT   = 2'd3
    } loadState_t;

endpackage

// File: rtl/iir_coeff_loader_bank.sv
// coeff_bank: N-entry register file, indexed write or parallel load,
// flattened parallel read (entry 0 in the LSBs).
// Ports: clk, rst, we/wIdx/wData (single write), ld/ldData (bulk load), q.
module coeff_bank #(
    parameter int W  = 13,
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [IW-1:0]  wIdx,
    input  logic [W-1:0]   wData,
    input  logic           ld,
    input  logic [W*N-1:0] ldData,
    output logic [W*N-1:0] q
);

    logic [W-1:0] mem [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (ld) begin
            for (int i = 0; i < N; i++) mem[i] <= ldData[i*W +: W];
        end else if (we && (int'(wIdx) < N)) begin
            mem[wIdx] <= wData;
        end
    end

    for (genvar g = 0; g < N; g++) begin : gRead
        assign q[g*W +: W] = mem[g];
    end

endmodule

// File: rtl/iir_coeff_loader.sv
// iir_coeff_loader: receives b0..bORD, a1..aORD as a word stream into a
// shadow bank and commits it to the active bank only in a vIn=0 gap.
// Ports: clk, rst (async high), cIn/cValid/cLast/cReady stream, vIn
// monitor, b/a active banks, coeff_ok (committed once), err (bad load).
module iir_coeff_loader
    import iir_pkg::*;
#(
    parameter int NB  = NB_DEF,
    parameter int ORD = ORD_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NB:0]             cIn,
    input  logic                    cValid,
    input  logic                    cLast,
    output logic                    cReady,
    input  logic                    vIn,
    output logic [(ORD+1)*(NB+1)-1:0] b,
    output logic [ORD*(NB+1)-1:0]   a,
    output logic                    coeff_ok,
    output logic                    err
);

    localparam int W  = NB + 1;
    localparam int NC = 2 * ORD + 1;
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);

    loadState_t    state;
    logic [IW-1:0] idx;
    logic          xfer;
    logic [W*NC-1:0] shadowQ;
    logic [W*NC-1:0] activeQ;

    // cReady is a pure decode of the state register
    assign cReady = (state == LOAD) || (state == DRAIN);
    assign xfer   = cValid && cReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            idx      <= '0;
            coeff_ok <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= cLast ? WAIT_GAP : DRAIN;
                            err   <= !cLast;
                        end else if (cLast) begin
                            // short load: restart, shadow gets overwritten
                            idx <= '0;
                            err <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (xfer && cLast) state <= LOAD;
                end
                WAIT_GAP: begin
                    if (!vIn) state <= COMMIT;
                end
                COMMIT: begin
                    state    <= LOAD;
                    coeff_ok <= 1'b1;
                end
            endcase
        end
    end

    coeff_bank #(.W(W), .N(NC), .IW(IW)) uShadow (
        .clk    (clk),
        .rst    (rst),
        .we     (xfer && (state == LOAD)),
        .wIdx   (idx),
        .wData  (cIn),
        .ld     (1'b0),
        .ldData ('0),
        .q      (shadowQ)
    );

    coeff_bank #(.W(W), .N(NC), .IW(IW)) uActive (
        .clk    (clk),
        .rst    (rst),
        .we     (1'b0),
        .wIdx   ('0),
        .wData  ('0),
        .ld     (state == COMMIT),
        .ldData (shadowQ),
        .q      (activeQ)
    );

    assign b = activeQ[(ORD+1)*W-1:0];
    assign a = activeQ[NC*W-1:(ORD+1)*W];

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Bench for iir_coeff_loader: scenario tasks plus a scoreboard that
// matches every change of the active bank against queued expectations.
module tb_iir_coeff_loader;

    localparam int W  = 13;
    localparam int NC = 5;

    logic          clk = 0;
    logic          rst = 0;
    logic [W-1:0]  cIn = '0;
    logic          cValid = 0;
    logic          cLast = 0;
    logic          cReady;
    logic          vIn = 0;
    logic [3*W-1:0] b;
    logic [2*W-1:0] a;
    logic          coeff_ok;
    logic          err;

    int tests = 0;
    int fails = 0;
    int errCount = 0;
    logic [W*NC-1:0] expQ [$];
    logic [W*NC-1:0] prevBA = '0;

    always #5 clk = ~clk;

    iir_coeff_loader dut (
        .clk      (clk),
        .rst      (rst),
        .cIn      (cIn),
        .cValid   (cValid),
        .cLast    (cLast),
        .cReady   (cReady),
        .vIn      (vIn),
        .b        (b),
        .a        (a),
        .coeff_ok (coeff_ok),
        .err      (err)
    );

    // Scoreboard: every change of {a,b} must match the oldest queued load
    always @(negedge clk) begin
        if (rst) begin
            prevBA = {a, b};
        end else begin
            if ({a, b} !== prevBA) begin
                tests++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected got=%h want=%h", {a, b}, prevBA);
                end else begin
                    logic [W*NC-1:0] e;
                    e = expQ.pop_front();
                    if ({a, b} !== e) begin
                        fails++;
                        $display("FAIL sb_commit got=%h want=%h", {a, b}, e);
                    end
                end
            end
            prevBA = {a, b};
            if (err) errCount++;
        end
    end

    task automatic send(input logic [W-1:0] w, input logic last);
        int n;
        @(negedge clk);
        cIn = w;
        cValid = 1;
        cLast = last;
        n = 0;
        while (!cReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout cReady=%b want=1", cReady);
        end
        @(posedge clk);
        #1;
        cValid = 0;
        cLast = 0;
    endtask

    task automatic fullLoad(input logic [W*NC-1:0] pk);
        expQ.push_back(pk);
        for (int i = 0; i < NC; i++)
            send(pk[i*W +: W], i == NC - 1);
    endtask

    task automatic test_reset;
        int bad;
        rst = 1;
        repeat (3) @(negedge clk);
        tests++;
        if ({a, b, coeff_ok, err} !== '0) begin
            fails++;
            $display("FAIL reset_outs got=%h want=0", {a, b, coeff_ok, err});
        end
        rst = 0;
        @(negedge clk);
        tests++;
        if (cReady !== 1'b1) begin
            fails++;
            $display("FAIL reset_cready got=%b want=1", cReady);
        end
        // cLast without cValid must be ignored
        cLast = 1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err !== 1'b0 || cReady !== 1'b1 || coeff_ok !== 1'b0) bad++;
        end
        cLast = 0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_idle bad_cycles=%0d want=0", bad);
        end
    endtask

    task automatic test_full_load;
        logic [W*NC-1:0] pk;
        int e0;
        pk = {13'h0300, 13'h1C00, 13'h0100, 13'h0200, 13'h0100};
        e0 = errCount;
        vIn = 0;
        fullLoad(pk);
        @(negedge clk);
        tests++;
        if (cReady !== 0 || {a, b} !== '0) begin
            fails++;
            $display("FAIL full_c1 cReady=%b ab=%h want 0/0", cReady, {a, b});
        end
        @(negedge clk);
        tests++;
        if (cReady !== 0 || {a, b} !== '0) begin
            fails++;
            $display("FAIL full_c2 cReady=%b ab=%h want 0/0", cReady, {a, b});
        end
        @(negedge clk);
        tests++;
        if (b !== {13'h0100, 13'h0200, 13'h0100} || a !== {13'h0300, 13'h1C00}) begin
            fails++;
            $display("FAIL full_bank b=%h a=%h want b=%h a=%h", b, a,
                     {13'h0100, 13'h0200, 13'h0100}, {13'h0300, 13'h1C00});
        end
        tests++;
        if (coeff_ok !== 1 || cReady !== 1 || errCount != e0) begin
            fails++;
            $display("FAIL full_flags ok=%b rdy=%b errs=%0d want 1/1/%0d",
                     coeff_ok, cReady, errCount, e0);
        end
    endtask

    task automatic test_vin_hold;
        logic [W*NC-1:0] pk;
        logic [W*NC-1:0] old;
        int bad, e0;
        pk = {13'h0005, 13'h0004, 13'h0003, 13'h0002, 13'h0001};
        old = {a, b};
        e0 = errCount;
        vIn = 1;
        fullLoad(pk);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({a, b} !== old || cReady !== 0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL vin_hold bad_cycles=%0d want=0", bad);
        end
        vIn = 0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({a, b} !== pk || errCount != e0) begin
            fails++;
            $display("FAIL vin_commit ab=%h errs=%0d want %h/%0d", {a, b},
                     errCount, pk, e0);
        end
    endtask

    task automatic test_short_load;
        logic [W*NC-1:0] old;
        logic [W*NC-1:0] pk;
        int e0;
        old = {a, b};
        e0 = errCount;
        send(13'h0AAA, 0);
        send(13'h0BBB, 0);
        send(13'h0CCC, 1);
        repeat (4) @(negedge clk);
        tests++;
        if (errCount != e0 + 1 || {a, b} !== old) begin
            fails++;
            $display("FAIL short_err errs=%0d ab=%h want %0d/%h", errCount,
                     {a, b}, e0 + 1, old);
        end
        pk = {13'h1FFF, 13'h1000, 13'h0FFF, 13'h0800, 13'h0001};
        fullLoad(pk);
        repeat (3) @(negedge clk);
        tests++;
        if ({a, b} !== pk) begin
            fails++;
            $display("FAIL short_reload ab=%h want %h", {a, b}, pk);
        end
    endtask

    task automatic test_long_load;
        logic [W*NC-1:0] old;
        int e0, bad;
        old = {a, b};
        e0 = errCount;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (cReady !== 1) bad++;
            send(13'h0100 + 13'(i), 0);
        end
        @(negedge clk);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL long_err_pulse err=%b want=1", err);
        end
        for (int i = 5; i < 7; i++) begin
            if (cReady !== 1) bad++;
            send(13'h0100 + 13'(i), i == 6);
        end
        repeat (4) @(negedge clk);
        if (cReady !== 1) bad++;
        tests++;
        if (bad != 0 || errCount != e0 + 1 || {a, b} !== old) begin
            fails++;
            $display("FAIL long_load rdyBad=%0d errs=%0d ab=%h want 0/%0d/%h",
                     bad, errCount, {a, b}, e0 + 1, old);
        end
    endtask

    task automatic test_reset_mid_load;
        logic [W*NC-1:0] pk;
        send(13'h0111, 0);
        send(13'h0222, 0);
        send(13'h0333, 0);
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        tests++;
        if (b !== '0 || a !== '0 || coeff_ok !== 0) begin
            fails++;
            $display("FAIL rst_mid b=%h a=%h ok=%b want 0/0/0", b, a, coeff_ok);
        end
        @(negedge clk);
        #2;
        rst = 0;
        pk = {13'h0044, 13'h0033, 13'h0022, 13'h0011, 13'h0ABC};
        fullLoad(pk);
        repeat (3) @(negedge clk);
        tests++;
        if ({a, b} !== pk || coeff_ok !== 1) begin
            fails++;
            $display("FAIL rst_reload ab=%h ok=%b want %h/1", {a, b}, coeff_ok, pk);
        end
    endtask

    task automatic test_back_to_back;
        logic [W*NC-1:0] p1;
        logic [W*NC-1:0] p2;
        p1 = {13'h1234, 13'h0567, 13'h089A, 13'h0BCD, 13'h0EF0};
        p2 = {13'h0F0F, 13'h10F0, 13'h0333, 13'h0CCC, 13'h1555};
        fullLoad(p1);
        fullLoad(p2);
        repeat (4) @(negedge clk);
        tests++;
        if ({a, b} !== p2 || expQ.size() != 0) begin
            fails++;
            $display("FAIL b2b ab=%h pending=%0d want %h/0", {a, b},
                     expQ.size(), p2);
        end
    endtask

    initial begin
        test_reset;
        test_full_load;
        test_vin_hold;
        test_short_load;
        test_long_load;
        test_reset_mid_load;
        test_back_to_back;
        repeat (5) @(negedge clk);
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL sb_pending left=%0d want=0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
